// File: rtl/rom_stream_reader.sv
// Streams LEN consecutive bytes from a combinational-read byte ROM, starting at BASE,
// out over a valid/ready interface with a one-cycle done pulse at the end.
module rom_stream_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_rd_en_o,
  output logic              rom_cs_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               load;
  logic               handshake;

  // A ROM read happens only when the output register is free or being emptied this cycle.
  assign load      = (state_q == RUN) && (remaining_q != '0) && (!out_valid_q || out_ready_i);
  assign handshake = out_valid_q && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (load) begin
      out_data_d  = rom_data_i;
      out_valid_d = 1'b1;
      ptr_d       = ptr_q + ADDR_W'(1);
      remaining_d = remaining_q - LEN_W'(1);
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // A zero-length request completes immediately without touching the ROM.
          if (len_i != '0) begin
            ptr_d       = base_addr_i;
            remaining_d = len_i;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (load && (remaining_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr_o  = ptr_q;
  assign rom_rd_en_o = load;
  assign rom_cs_o    = load;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed self-checking bench for rom_stream_reader against a ROM whose
// contents are addr[7:0] ^ 8'h20.
module tb_rom_stream_reader;

  logic       clk;
  logic       rstN;
  logic       startIn;
  logic [8:0] baseIn;
  logic [9:0] lenIn;
  logic [8:0] romAddr;
  logic       romRdEn;
  logic       romCs;
  logic [7:0] romData;
  logic [7:0] outData;
  logic       outValid;
  logic       readyIn;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  rom_stream_reader dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .start_i     (startIn),
    .base_addr_i (baseIn),
    .len_i       (lenIn),
    .rom_addr_o  (romAddr),
    .rom_rd_en_o (romRdEn),
    .rom_cs_o    (romCs),
    .rom_data_i  (romData),
    .out_data_o  (outData),
    .out_valid_o (outValid),
    .out_ready_i (readyIn),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign romData = romAddr[7:0] ^ 8'h20;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] base, input logic [9:0] len);
    startIn = 1'b1;
    baseIn  = base;
    lenIn   = len;
    stepClk();
    startIn = 1'b0;
  endtask

  initial begin
    logic [8:0] wrapAddr [4];
    logic [7:0] wrapData [4];
    logic [3:0] readyPat;
    logic       prevStall;
    logic [7:0] prevData;
    logic       gotDone;
    int         nRecv;
    int         doneCount;

    wrapAddr = '{9'd510, 9'd511, 9'd0, 9'd1};
    wrapData = '{8'hDE, 8'hDF, 8'h20, 8'h21};
    readyPat = 4'b1001;

    rstN    = 1'b1;
    startIn = 1'b0;
    baseIn  = '0;
    lenIn   = '0;
    readyIn = 1'b0;

    // Reset asserted between clock edges must clear outputs immediately
    #3 rstN = 1'b0;
    #1;
    checkOutput("rst_valid", 16'(outValid), 16'h0);
    checkOutput("rst_data", 16'(outData), 16'h0);
    checkOutput("rst_addr", 16'(romAddr), 16'h0);
    checkOutput("rst_cs", 16'(romCs), 16'h0);
    checkOutput("rst_rden", 16'(romRdEn), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    stepClk();
    stepClk();
    rstN = 1'b1;
    stepClk();

    $display("[TB] back-to-back base=0 len=4");
    readyIn = 1'b1;
    applyStimulus(9'd0, 10'd4);
    checkOutput("b2b_busy", 16'(busy), 16'h1);
    checkOutput("b2b_first_valid", 16'(outValid), 16'h0);
    checkOutput("b2b_addr0", 16'(romAddr), 16'h0);
    checkOutput("b2b_cs0", 16'(romCs), 16'h1);
    for (int i = 0; i < 4; i++) begin
      stepClk();
      checkOutput("b2b_valid", 16'(outValid), 16'h1);
      checkOutput("b2b_data", 16'(outData), 16'(8'h20 + i));
      checkOutput("b2b_done_early", 16'(done), 16'h0);
      if (i < 3) begin
        checkOutput("b2b_addr", 16'(romAddr), 16'(i + 1));
        checkOutput("b2b_cs", 16'(romCs), 16'h1);
      end else begin
        checkOutput("b2b_cs_drain", 16'(romCs), 16'h0);
        checkOutput("b2b_busy_drain", 16'(busy), 16'h1);
      end
    end
    stepClk();
    checkOutput("b2b_done", 16'(done), 16'h1);
    checkOutput("b2b_busy_end", 16'(busy), 16'h0);
    checkOutput("b2b_valid_end", 16'(outValid), 16'h0);
    stepClk();
    checkOutput("b2b_done_pulse", 16'(done), 16'h0);

    $display("[TB] backpressure base=16 len=5");
    applyStimulus(9'd16, 10'd5);
    prevStall = 1'b0;
    prevData  = '0;
    gotDone   = 1'b0;
    nRecv     = 0;
    doneCount = 0;
    for (int c = 0; c < 40 && !gotDone; c++) begin
      readyIn = readyPat[3 - (c % 4)];
      #1;
      if (prevStall) begin
        checkOutput("bp_hold_valid", 16'(outValid), 16'h1);
        checkOutput("bp_hold_data", 16'(outData), 16'(prevData));
      end
      if (outValid && readyIn) begin
        checkOutput("bp_data", 16'(outData), 16'(8'h30 + nRecv));
        nRecv++;
      end
      if (outValid && !readyIn) begin
        checkOutput("bp_stall_cs", 16'(romCs), 16'h0);
      end
      prevStall = outValid && !readyIn;
      prevData  = outData;
      stepClk();
      if (done) begin
        gotDone = 1'b1;
        doneCount++;
      end
    end
    checkOutput("bp_count", 16'(nRecv), 16'd5);
    checkOutput("bp_done_seen", 16'(doneCount), 16'd1);
    checkOutput("bp_busy_end", 16'(busy), 16'h0);
    readyIn = 1'b1;
    stepClk();

    $display("[TB] wrap base=510 len=4");
    applyStimulus(9'd510, 10'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_addr", 16'(romAddr), 16'(wrapAddr[i]));
      stepClk();
      checkOutput("wrap_data", 16'(outData), 16'(wrapData[i]));
    end
    stepClk();
    checkOutput("wrap_done", 16'(done), 16'h1);
    stepClk();

    $display("[TB] zero length");
    startIn = 1'b1;
    baseIn  = 9'd7;
    lenIn   = 10'd0;
    #1;
    checkOutput("zero_cs_pre", 16'(romCs), 16'h0);
    stepClk();
    startIn = 1'b0;
    checkOutput("zero_done", 16'(done), 16'h1);
    checkOutput("zero_busy", 16'(busy), 16'h0);
    checkOutput("zero_valid", 16'(outValid), 16'h0);
    checkOutput("zero_cs", 16'(romCs), 16'h0);
    stepClk();
    checkOutput("zero_done_pulse", 16'(done), 16'h0);
    checkOutput("zero_valid_after", 16'(outValid), 16'h0);

    $display("[TB] abort and restart");
    applyStimulus(9'd100, 10'd6);
    stepClk();
    checkOutput("abort_d0", 16'(outData), 16'h44);
    stepClk();
    checkOutput("abort_d1", 16'(outData), 16'h45);
    startIn = 1'b1;
    baseIn  = 9'd0;
    lenIn   = 10'd1;
    stepClk();
    startIn = 1'b0;
    checkOutput("ignore_start_data", 16'(outData), 16'h46);
    checkOutput("ignore_start_addr", 16'(romAddr), 16'd103);
    checkOutput("ignore_start_busy", 16'(busy), 16'h1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abort_valid", 16'(outValid), 16'h0);
    checkOutput("abort_data", 16'(outData), 16'h0);
    checkOutput("abort_busy", 16'(busy), 16'h0);
    checkOutput("abort_cs", 16'(romCs), 16'h0);
    checkOutput("abort_addr", 16'(romAddr), 16'h0);
    checkOutput("abort_done", 16'(done), 16'h0);
    stepClk();
    checkOutput("abort_done_held", 16'(done), 16'h0);
    rstN = 1'b1;
    stepClk();
    checkOutput("abort_done_after", 16'(done), 16'h0);
    checkOutput("abort_busy_after", 16'(busy), 16'h0);

    applyStimulus(9'd200, 10'd2);
    stepClk();
    checkOutput("restart_d0", 16'(outData), 16'hE8);
    stepClk();
    checkOutput("restart_d1", 16'(outData), 16'hE9);
    stepClk();
    checkOutput("restart_done", 16'(done), 16'h1);
    checkOutput("restart_busy", 16'(busy), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
